core_memory: RTL and testbench

CORE_MEMORY -- requirements
Module: core_memory

---
 rtl/core_memory_pkg.sv | 13 +
 rtl/core_memory_store_buffer.sv | 48 ++++
 rtl/core_memory.sv | 130 +++++++++++++
 tb/tb_core_memory.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core_memory_pkg.sv
// Shared core definitions: data width and word-index sizing for the core memory.
package core_memory_pkg;

    localparam int CORE_XLEN = 32;
    localparam int WORD_W    = 32;

    typedef logic [WORD_W-1:0] word_t;

    function automatic int word_idx_w(input int depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/core_memory_store_buffer.sv
// One-entry store buffer: captures an accepted write, commits it one edge later,
// and flags read/fetch indices that hit the pending entry.
module store_buffer
    import core_memory_pkg::*;
#(
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_vld,
    input  logic [IW-1:0] i_wr_idx,
    input  word_t         i_wr_dat,
    input  logic [IW-1:0] i_rd_idx,
    input  logic [IW-1:0] i_if_idx,
    output logic          o_cmt_vld,
    output logic [IW-1:0] o_cmt_idx,
    output word_t         o_cmt_dat,
    output logic          o_rd_hit,
    output logic          o_if_hit
);

    logic          r_vld;
    logic [IW-1:0] r_idx;
    word_t         r_dat;

    // A new write replaces the entry that is committing at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= i_wr_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_vld) begin
            r_idx <= i_wr_idx;
            r_dat <= i_wr_dat;
        end
    end

    assign o_cmt_vld = r_vld;
    assign o_cmt_idx = r_idx;
    assign o_cmt_dat = r_dat;
    assign o_rd_hit  = r_vld && (r_idx == i_rd_idx);
    assign o_if_hit  = r_vld && (r_idx == i_if_idx);

endmodule

// File: rtl/core_memory.sv
// Unified instruction/data word memory with 1-cycle registered reads and a store buffer.
// Optional CORE_MEMORY_PERF_COUNT_EN adds read/commit counters at DEPTH_WORDS*4 and +4.
module core_memory
    import core_memory_pkg::*;
#(
    parameter int XLEN          = CORE_XLEN,
    parameter int DEPTH_WORDS   = 1024,
    parameter int MISALIGN_TRAP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr_addr,
    output logic [31:0]     instr_in,
    input  logic            data_re,
    input  logic            data_we,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] data_out,
    output logic [XLEN-1:0] data_in,
    output logic            misalign_err
);

    localparam int IW = word_idx_w(DEPTH_WORDS);

    word_t           r_mem [DEPTH_WORDS];
    word_t           r_instr;
    logic [XLEN-1:0] r_din;
    logic            r_mis;

    logic [IW-1:0]   w_rd_idx;
    logic [IW-1:0]   w_if_idx;
    logic            w_mis;
    logic            w_wr_acc;
    logic            w_cmt_vld;
    logic [IW-1:0]   w_cmt_idx;
    word_t           w_cmt_dat;
    logic            w_sb_rd_hit;
    logic            w_sb_if_hit;
    word_t           w_rd_word;
    word_t           w_if_word;
    logic [XLEN-1:0] w_rd_val;

    assign w_rd_idx = data_addr[IW+1:2];
    assign w_if_idx = instr_addr[IW+1:2];
    assign w_mis    = (MISALIGN_TRAP != 0) && (data_addr[1:0] != 2'b00);
    assign w_wr_acc = data_we && !w_mis;

    store_buffer #(.IW(IW)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_wr_vld  (w_wr_acc),
        .i_wr_idx  (w_rd_idx),
        .i_wr_dat  (data_out[WORD_W-1:0]),
        .i_rd_idx  (w_rd_idx),
        .i_if_idx  (w_if_idx),
        .o_cmt_vld (w_cmt_vld),
        .o_cmt_idx (w_cmt_idx),
        .o_cmt_dat (w_cmt_dat),
        .o_rd_hit  (w_sb_rd_hit),
        .o_if_hit  (w_sb_if_hit)
    );

    always_ff @(posedge clk) begin
        if (w_cmt_vld) begin
            r_mem[w_cmt_idx] <= w_cmt_dat;
        end
    end

    // Read and write share data_addr, so a same-cycle write is always to the read word.
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_acc) begin
            w_rd_word = data_out[WORD_W-1:0];
        end else if (w_sb_rd_hit) begin
            w_rd_word = w_cmt_dat;
        end
    end

    assign w_if_word = w_sb_if_hit ? w_cmt_dat : r_mem[w_if_idx];

`ifdef CORE_MEMORY_PERF_COUNT_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else begin
            if (data_re)   r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_cmt_vld) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    always_comb begin
        w_rd_val = XLEN'(w_rd_word);
        if (data_addr == XLEN'(DEPTH_WORDS * 4)) begin
            w_rd_val = XLEN'(r_rd_cnt);
        end else if (data_addr == XLEN'(DEPTH_WORDS * 4 + 4)) begin
            w_rd_val = XLEN'(r_wr_cnt);
        end
    end
`else
    assign w_rd_val = XLEN'(w_rd_word);

    logic w_unused;
    assign w_unused = ^{data_addr[XLEN-1:IW+2]};
`endif

    logic w_unused_if;
    assign w_unused_if = ^{instr_addr[XLEN-1:IW+2], instr_addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr <= '0;
            r_din   <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_instr <= w_if_word;
            if (data_re) begin
                r_din <= w_rd_val;
            end
            r_mis <= r_mis | ((data_re | data_we) & w_mis);
        end
    end

    assign instr_in     = r_instr;
    assign data_in      = r_din;
    assign misalign_err = r_mis;

endmodule

// File: tb/tb_core_memory.sv
// Bench for core_memory: directed vector table, reset-with-pending-write sequence,
// and randomized traffic checked against an architectural memory model.
module tb_core_memory;

    localparam int DEPTH = 1024;
    localparam int WIN   = 32;

    logic        clk;
    logic        rst;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic        data_re;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        misalign_err;

    int n_pass;
    int n_total;

    core_memory #(.XLEN(32), .DEPTH_WORDS(DEPTH), .MISALIGN_TRAP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_addr   (instr_addr),
        .instr_in     (instr_in),
        .data_re      (data_re),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_out     (data_out),
        .data_in      (data_in),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] iaddr;
        logic [31:0] exp_din;
        logic [31:0] exp_ins;
        logic        exp_mis;
    } vec_t;

    vec_t tbl [15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] ia);
        data_re    = re;
        data_we    = we;
        data_addr  = a;
        data_out   = d;
        instr_addr = ia;
    endtask

    logic [31:0] m [WIN];
    logic [31:0] exp_din;
    logic        exp_mis;
    logic [31:0] exp_ins;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("reset data_in", data_in, 32'h0);
        check("reset instr_in", instr_in, 32'h0);
        check("reset misalign_err", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;

        // Preload the working window; word 0 holds a NOP (addi x0,x0,0).
        for (int i = 0; i < 2 * WIN; i++) begin
            drive(1'b0, 1'b1, 32'(i * 4), (i == 0) ? 32'h13 : 32'h0, 32'h0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();

        //          re    we    addr      wdat          iaddr     exp_din       exp_ins       mis
        tbl[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 32'h0,    32'h0,        32'h13,       1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        32'h10,   32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h1000, 32'hDEADBEEF, 32'h13,       1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h0,    32'hDEADBEEF, 32'h13,       1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h0,    32'hDEADBEEF, 32'h13,       1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        32'h0,    32'hDEADBEEF, 32'h13,       1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h20,   32'h12345678, 32'h10,   32'h12345678, 32'hDEADBEEF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h40,   32'h1,        32'h20,   32'h12345678, 32'h12345678, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h40,   32'h2,        32'h40,   32'h12345678, 32'h1,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h40,   32'h0,        32'h40,   32'h2,        32'h2,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h40,   32'h0,        32'h1040, 32'h2,        32'h2,        1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h41,   32'hFFFFFFFF, 32'h0,    32'h2,        32'h13,       1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h40,   32'h0,        32'h40,   32'h2,        32'h2,        1'b1};
        tbl[13] = '{1'b1, 1'b0, 32'h43,   32'h0,        32'h0,    32'h2,        32'h13,       1'b1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h0,    32'h2,        32'h13,       1'b1};

        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].re, tbl[v].we, tbl[v].addr, tbl[v].wdat, tbl[v].iaddr);
            step();
            check($sformatf("vec%0d data_in", v), data_in, tbl[v].exp_din);
            check($sformatf("vec%0d instr_in", v), instr_in, tbl[v].exp_ins);
            check($sformatf("vec%0d misalign_err", v), {31'b0, misalign_err}, {31'b0, tbl[v].exp_mis});
        end

        // Reset with a write still sitting in the store buffer.
        drive(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 32'h30);
        step();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 32'h10);
        #1;
        check("async rst data_in", data_in, 32'h0);
        check("async rst misalign_err", {31'b0, misalign_err}, 32'h0);
        check("async rst instr_in", instr_in, 32'h0);
        step();
        check("read ignored in rst", data_in, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h30, 32'h0, 32'h30);
        step();
        check("pending write dropped", data_in, 32'h0);
        check("pending write dropped ifetch", instr_in, 32'h0);
        drive(1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        step();
        check("array kept over rst", data_in, 32'hDEADBEEF);
        check("misalign clear after rst", {31'b0, misalign_err}, 32'h0);

        // Randomized traffic against an architectural model of the window.
        for (int i = 0; i < WIN; i++) begin
            m[i] = $urandom;
            drive(1'b0, 1'b1, 32'(i * 4), m[i], 32'h0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        exp_din = 32'hDEADBEEF;
        exp_mis = 1'b0;

        for (int c = 0; c < 400; c++) begin
            automatic int          idx  = int'($urandom_range(0, WIN - 1));
            automatic int          iidx = int'($urandom_range(0, WIN - 1));
            automatic logic [1:0]  lo   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            automatic logic        re   = 1'($urandom_range(0, 1));
            automatic logic        we   = ($urandom_range(0, 4) < 2);
            automatic logic [31:0] wd   = $urandom;
            automatic logic [31:0] a    = 32'($urandom_range(0, 3) * DEPTH * 4 + idx * 4) | {30'b0, lo};
            automatic logic [31:0] ia   = 32'($urandom_range(0, 3) * DEPTH * 4 + iidx * 4);

            exp_ins = m[iidx];
            if (we && lo == 2'b00) m[idx] = wd;
            if (re) exp_din = m[idx];
            if ((re || we) && lo != 2'b00) exp_mis = 1'b1;

            drive(re, we, a, wd, ia);
            step();
            check($sformatf("rand%0d data_in", c), data_in, exp_din);
            check($sformatf("rand%0d instr_in", c), instr_in, exp_ins);
            check($sformatf("rand%0d misalign_err", c), {31'b0, misalign_err}, {31'b0, exp_mis});
        end

        drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
